// File: rtl/rr_onehot_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter_if
// Bundles the request vector and the valid/ready grant channel of the
// round-robin arbiter.
//   req       : request vector, bit i = requester i (multi-hot allowed)
//   gnt_valid : gnt/gnt_idx carry a valid grant
//   gnt_ready : downstream accepts the grant when gnt_valid && gnt_ready
//   gnt       : one-hot grant, all-zero when gnt_valid=0
//   gnt_idx   : binary index of the set bit in gnt, zero when gnt_valid=0
// Modports:
//   master : the arbiter, which produces the grant channel
//   slave  : the environment, which raises requests and consumes grants
// -----------------------------------------------------------------------------
interface rr_onehot_arbiter_if #(
    parameter int BITS = 3
);
    localparam int OUT_BITS = 1 << BITS;

    logic [OUT_BITS-1:0] req;
    logic                gnt_valid;
    logic                gnt_ready;
    logic [OUT_BITS-1:0] gnt;
    logic [BITS-1:0]     gnt_idx;

    modport master (
        input  req,
        input  gnt_ready,
        output gnt_valid,
        output gnt,
        output gnt_idx
    );

    modport slave (
        output req,
        output gnt_ready,
        input  gnt_valid,
        input  gnt,
        input  gnt_idx
    );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
// Round-robin arbiter over a one-hot/multi-hot request vector. One requester is
// granted per handshake; the grant (one-hot and binary index) is registered and
// held bit-stable until downstream accepts it, so the consumer may stall freely.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_onehot_arbiter_if.master (req, gnt_valid, gnt_ready, gnt, gnt_idx)
// All outputs come straight from flops; req and gnt_ready only steer the
// next-state logic.
// -----------------------------------------------------------------------------
module rr_onehot_arbiter #(
    parameter int BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_onehot_arbiter_if.master  bus
);
    localparam int OUT_BITS = 1 << BITS;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [BITS-1:0]     ptr_r;
    logic [BITS-1:0]     ptr_nxt_s;
    logic                gnt_valid_r;
    logic                gnt_valid_nxt_s;
    logic [OUT_BITS-1:0] gnt_r;
    logic [OUT_BITS-1:0] gnt_nxt_s;
    logic [BITS-1:0]     gnt_idx_r;
    logic [BITS-1:0]     gnt_idx_nxt_s;
    logic                handshake_s;
    logic [BITS-1:0]     base_s;
    logic                found_s;
    logic [BITS-1:0]     win_idx_s;

    // Scan req starting just after 'last' and wrapping back to 'last'
    // inclusive; returns {found, index}. The BITS-bit addition provides the
    // modulo-OUT_BITS wrap for free.
    function automatic logic [BITS:0] find_winner(
        input logic [OUT_BITS-1:0] r,
        input logic [BITS-1:0]     last
    );
        logic            found;
        logic [BITS-1:0] idx;
        logic [BITS-1:0] cand;
        found = 1'b0;
        idx   = {BITS{1'b0}};
        for (int k = 1; k <= OUT_BITS; k++) begin
            cand = last + k[BITS-1:0];
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Binary index to one-hot vector.
    function automatic logic [OUT_BITS-1:0] to_onehot(input logic [BITS-1:0] i);
        return {{(OUT_BITS-1){1'b0}}, 1'b1} << i;
    endfunction

    // Winner search: on a handshake the pointer moves to the accepted index in
    // the same edge, so the search must already start after gnt_idx.
    always_comb begin
        handshake_s            = (state_r == GRANT) && bus.gnt_ready;
        base_s                 = handshake_s ? gnt_idx_r : ptr_r;
        {found_s, win_idx_s}   = find_winner(bus.req, base_s);
    end

    // Next-state and next-output logic of the two-state FSM.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        gnt_valid_nxt_s = gnt_valid_r;
        gnt_nxt_s       = gnt_r;
        gnt_idx_nxt_s   = gnt_idx_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt_s     = GRANT;
                    gnt_valid_nxt_s = 1'b1;
                    gnt_nxt_s       = to_onehot(win_idx_s);
                    gnt_idx_nxt_s   = win_idx_s;
                end else begin
                    state_nxt_s     = IDLE;
                    gnt_valid_nxt_s = 1'b0;
                    gnt_nxt_s       = {OUT_BITS{1'b0}};
                    gnt_idx_nxt_s   = {BITS{1'b0}};
                end
            end
            GRANT: begin
                if (handshake_s) begin
                    ptr_nxt_s = gnt_idx_r;
                    if (found_s) begin
                        // Back-to-back grant, no bubble.
                        state_nxt_s     = GRANT;
                        gnt_valid_nxt_s = 1'b1;
                        gnt_nxt_s       = to_onehot(win_idx_s);
                        gnt_idx_nxt_s   = win_idx_s;
                    end else begin
                        state_nxt_s     = IDLE;
                        gnt_valid_nxt_s = 1'b0;
                        gnt_nxt_s       = {OUT_BITS{1'b0}};
                        gnt_idx_nxt_s   = {BITS{1'b0}};
                    end
                end else begin
                    // Stalled: hold the grant regardless of req changes.
                    state_nxt_s     = GRANT;
                    gnt_valid_nxt_s = gnt_valid_r;
                    gnt_nxt_s       = gnt_r;
                    gnt_idx_nxt_s   = gnt_idx_r;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                ptr_nxt_s       = {BITS{1'b1}};
                gnt_valid_nxt_s = 1'b0;
                gnt_nxt_s       = {OUT_BITS{1'b0}};
                gnt_idx_nxt_s   = {BITS{1'b0}};
            end
        endcase
    end

    // State, pointer and output registers. Pointer resets to the top index so
    // requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= {BITS{1'b1}};
            gnt_valid_r <= 1'b0;
            gnt_r       <= {OUT_BITS{1'b0}};
            gnt_idx_r   <= {BITS{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_idx_r   <= gnt_idx_nxt_s;
        end
    end

    assign bus.gnt_valid = gnt_valid_r;
    assign bus.gnt       = gnt_r;
    assign bus.gnt_idx   = gnt_idx_r;

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that consumes a one-hot/multi-hot request vector, as produced by the shift-based binary-to-one-hot decoder stage.
- Grants exactly one requester per handshake.
- Presents both the one-hot grant and its binary index downstream over a valid/ready interface.
- Grant is registered and held stable until accepted, so downstream may stall arbitrarily.

Parameters:
- BITS, 3, width of binary grant index.
- OUT_BITS, 1 << BITS, request/grant vector width. Local parameter, derived from BITS, not overridable.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  OUT_BITS  request vector; bit i = requester i. Multiple bits may be set.
- gnt_valid  output  1  gnt/gnt_idx hold a valid grant.
- gnt_ready  input  1  downstream accepts grant when gnt_valid && gnt_ready at rising clk.
- gnt  output  OUT_BITS  one-hot grant; all-zero when gnt_valid=0.
- gnt_idx  output  BITS  binary index of set bit in gnt; 0 when gnt_valid=0.

Behaviour:
- Reset (rst_n low, async, takes effect without a clock edge):
  - gnt_valid=0, gnt=0, gnt_idx=0.
  - Internal last-grant pointer ptr=OUT_BITS-1, so index 0 has first priority.
  - State=IDLE.
- Winner search:
  - Scan from (ptr+1) mod OUT_BITS upward, wrapping at OUT_BITS-1 to 0, ending at ptr inclusive.
  - First set req bit wins.
  - All index arithmetic is modulo OUT_BITS (BITS-bit wrap).
- State IDLE:
  - If |req at rising clk: register winner into gnt/gnt_idx, set gnt_valid=1, go to GRANT. Latency: req asserted -> gnt_valid high 1 cycle later.
  - If req==0: remain in IDLE, outputs stay zero.
- State GRANT, no handshake (gnt_valid && !gnt_ready):
  - gnt, gnt_idx, gnt_valid held bit-stable.
  - req changes, including withdrawal of the granted bit, are ignored.
- State GRANT, handshake (gnt_valid && gnt_ready):
  - ptr <= gnt_idx.
  - Same edge: search current req using the updated ptr (winner starts at gnt_idx+1).
  - If any req bit set: load new winner, keep gnt_valid=1. Back-to-back grants, no bubble.
  - Else: gnt_valid=0, gnt=0, gnt_idx=0, go to IDLE.
- Requester behaviour:
  - A lone requester re-wins every handshake.
  - A requester is never granted twice in a row while another requester is active.
  - Any continuously asserted requester is granted within OUT_BITS handshakes.
- gnt_ready while gnt_valid=0: ignored.
- Invariant: gnt == (gnt_valid ? 1 << gnt_idx : 0) on every cycle.
- Reset asserted mid-grant: grant is discarded, with no handshake implied. After release, arbitration restarts from index 0 priority.
- Implementation: two-state FSM plus registered outputs. No combinational path from req or gnt_ready to any output.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with gnt_valid=1 -> gnt_valid=0, gnt=8'h00, gnt_idx=0 before next clk edge. Release, req=8'h10 -> 1 cycle later gnt=8'h10, gnt_idx=4.
- Alternation: req=8'h05 constant, gnt_ready=1 -> gnt_idx sequence 0,2,0,2 on consecutive cycles. gnt_valid stays 1, no bubbles.
- Full rotation: req=8'hFF, gnt_ready=1 -> gnt_idx 0,1,...,7,0. gnt=8'h01,8'h02,...,8'h80,8'h01.
- Stall/hold: req=8'h80, gnt_ready=0 for 5 cycles, req->8'h00 at cycle 2 -> gnt=8'h80, gnt_idx=7 held all 5 cycles. Then gnt_ready=1 -> next cycle gnt_valid=0, gnt=8'h00.
- Wrap-around: after handshake of idx 7, req=8'h81 -> next grant idx 0, then idx 7, then idx 0 (fairness across the wrap point).
- Idle start latency: req=0 for 3 cycles (outputs zero), then req=8'h06 -> gnt_valid rises exactly 1 cycle later with idx 1. After handshake, idx 2.
